// File: rtl/button_conditioner_pkg.sv
// Shared types and default constants for the button conditioner.
package button_conditioner_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int DATA_W_DEF          = 6;

    typedef enum logic [1:0] {
        DB_IDLE         = 2'd0,
        DB_PRESS_WAIT   = 2'd1,
        DB_PRESSED      = 2'd2,
        DB_RELEASE_WAIT = 2'd3
    } db_state_e;

endpackage

// File: rtl/button_conditioner_debounce_fsm.sv
// Per-button synchronizer, saturating stability counter and debounce FSM.
//
// state           | meaning
// ----------------+--------------------------------------------------------
// DB_IDLE         | button released and stable
// DB_PRESS_WAIT   | synced level high, counting toward a stable press
// DB_PRESSED      | press accepted; held, no repeat events
// DB_RELEASE_WAIT | synced level low, counting toward a stable release
//
// press_o is high for exactly the cycle in which the FSM is about to enter
// DB_PRESSED. It is decoded from flops only (no path from btn_raw), so the
// parent can register its output pulse on the same edge the FSM moves.
module debounce_fsm
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    db_state_e       state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   count_inc;
    logic            press;

    // Next-state, counter and press-event decode.
    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        state_d   = state_q;
        count_d   = count_q;
        press     = 1'b0;
        count_inc = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
        case (state_q)
            DB_IDLE: begin
                if (sync2_q) begin
                    state_d = DB_PRESS_WAIT;
                    count_d = CNT_ONE;
                end
            end
            DB_PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = DB_IDLE;
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    state_d = DB_PRESSED;
                    count_d = '0;
                    press   = 1'b1;
                end else begin
                    count_d = count_inc;
                end
            end
            DB_PRESSED: begin
                if (!sync2_q) begin
                    state_d = DB_RELEASE_WAIT;
                    count_d = CNT_ONE;
                end
            end
            DB_RELEASE_WAIT: begin
                if (sync2_q) begin
                    state_d = DB_PRESSED;
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    state_d = DB_IDLE;
                    count_d = '0;
                end else begin
                    count_d = count_inc;
                end
            end
            default: begin
                state_d = DB_IDLE;
                count_d = '0;
            end
        endcase
    end

    // State, counter and synchronizer registers; reset drops any pending event.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= DB_IDLE;
            count_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign press_o = press;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the Next/Done pushbuttons and data switches for the Turing
// machine: one debounced pulse per press, Done wins a same-edge tie, and the
// switch value is captured alongside each Next pulse.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int DATA_W          = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              next_btn,
    input  logic              done_btn,
    input  logic [DATA_W-1:0] data_sw,
    output logic              Next,
    output logic              Done,
    output logic [DATA_W-1:0] input_data
);

    logic              next_press;
    logic              done_press;
    logic [DATA_W-1:0] data_s1_q, data_s1_d;
    logic [DATA_W-1:0] data_s2_q, data_s2_d;
    logic              next_q, next_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] data_q, data_d;

    debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
        .clock   (clock),
        .reset   (reset),
        .btn_raw (next_btn),
        .press_o (next_press)
    );

    debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_done_db (
        .clock   (clock),
        .reset   (reset),
        .btn_raw (done_btn),
        .press_o (done_press)
    );

    // Done has priority; data is captured only on an actual Next pulse.
    always_comb begin
        data_s1_d = data_sw;
        data_s2_d = data_s1_q;
        done_d    = done_press;
        next_d    = next_press & ~done_press;
        data_d    = next_d ? data_s2_q : data_q;
    end

    // Switch synchronizer and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_s1_q <= '0;
            data_s2_q <= '0;
            next_q    <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= '0;
        end else begin
            data_s1_q <= data_s1_d;
            data_s2_q <= data_s2_d;
            next_q    <= next_d;
            done_q    <= done_d;
            data_q    <= data_d;
        end
    end

    assign Next       = next_q;
    assign Done       = done_q;
    assign input_data = data_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, DATA_W=6.
// Inputs change 1 ns after a rising edge; a level set there is first sampled
// at the next edge k, and a clean press pulses at edge k+5, i.e. on the 6th
// tick after the change.
module tb_button_conditioner;
    import button_conditioner_pkg::*;

    localparam int DC       = 4;
    localparam int DW       = 6;
    localparam int PULSE_AT = DC + 2;

    logic          clock    = 1'b0;
    logic          reset    = 1'b0;
    logic          next_btn = 1'b0;
    logic          done_btn = 1'b0;
    logic [DW-1:0] data_sw  = '0;
    logic          Next;
    logic          Done;
    logic [DW-1:0] input_data;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    button_conditioner #(.DEBOUNCE_CYCLES(DC), .DATA_W(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .next_btn   (next_btn),
        .done_btn   (done_btn),
        .data_sw    (data_sw),
        .Next       (Next),
        .Done       (Done),
        .input_data (input_data)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Runs n ticks; expects exactly one pulse on tick pulse_at (0 = none)
    // on Next (is_next=1) or Done (is_next=0), with input_data = exp_data then.
    task automatic window(input string tag, input int n, input int pulse_at,
                          input bit is_next, input logic [DW-1:0] exp_data);
        for (int i = 1; i <= n; i++) begin
            tick();
            chk({tag, "_next"}, 32'(Next), 32'(is_next && i == pulse_at));
            chk({tag, "_done"}, 32'(Done), 32'(!is_next && i == pulse_at));
            if (i == pulse_at)
                chk({tag, "_data"}, 32'(input_data), 32'(exp_data));
        end
    endtask

    logic [DW-1:0] seq_vals [9];

    initial begin
        seq_vals = '{6'd1, 6'd1, 6'd1, 6'd1, 6'd0, 6'd1, 6'd1, 6'd1, 6'd0};

        // Reset state
        reset = 1'b0;
        #1;
        chk("rst_next", 32'(Next), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_data", 32'(input_data), 32'd0);
        tick(); tick(); tick();
        chk("rst_idle", 32'(dut.u_next_db.state_q), 32'(DB_IDLE));
        reset = 1'b1;
        tick();

        // Clean press, long hold, clean release
        data_sw  = 6'd3;
        next_btn = 1'b1;
        window("clean", 20, PULSE_AT, 1'b1, 6'd3);
        next_btn = 1'b0;
        window("clean_rel", 10, 0, 1'b1, 6'd3);
        chk("clean_hold", 32'(input_data), 32'd3);

        // Bounce on press and on release
        data_sw = 6'd5;
        next_btn = 1'b1; tick(); chk("bnc_a", 32'(Next), 32'd0);
        next_btn = 1'b0; tick(); chk("bnc_b", 32'(Next), 32'd0);
        next_btn = 1'b1; tick(); chk("bnc_c", 32'(Next), 32'd0);
        next_btn = 1'b0; tick(); chk("bnc_d", 32'(Next), 32'd0);
        next_btn = 1'b1;
        window("bounce", 12, PULSE_AT, 1'b1, 6'd5);
        next_btn = 1'b0; tick(); chk("rbnc_a", 32'(Next), 32'd0);
        next_btn = 1'b1; tick(); chk("rbnc_b", 32'(Next), 32'd0);
        next_btn = 1'b0; tick(); chk("rbnc_c", 32'(Next), 32'd0);
        next_btn = 1'b1; tick(); chk("rbnc_d", 32'(Next), 32'd0);
        next_btn = 1'b0;
        window("bounce_rel", 12, 0, 1'b1, 6'd5);
        chk("bounce_data", 32'(input_data), 32'd5);
        chk("bounce_idle", 32'(dut.u_next_db.state_q), 32'(DB_IDLE));

        // Glitch on Done: two samples only
        done_btn = 1'b1; tick(); chk("glitch_a", 32'(Done), 32'd0);
        tick(); chk("glitch_b", 32'(Done), 32'd0);
        done_btn = 1'b0;
        window("glitch", 10, 0, 1'b0, 6'd5);
        chk("glitch_idle", 32'(dut.u_done_db.state_q), 32'(DB_IDLE));

        // Simultaneous presses: Done wins, data not captured
        data_sw  = 6'd32;
        next_btn = 1'b1;
        done_btn = 1'b1;
        window("simul", 10, PULSE_AT, 1'b0, 6'd5);
        chk("simul_data", 32'(input_data), 32'd5);
        chk("simul_nstate", 32'(dut.u_next_db.state_q), 32'(DB_PRESSED));
        next_btn = 1'b0;
        done_btn = 1'b0;
        window("simul_rel", 10, 0, 1'b1, 6'd5);

        // Reset mid-debounce with the button held throughout
        data_sw  = 6'd9;
        next_btn = 1'b1;
        tick(); chk("rmid_a", 32'(Next), 32'd0);
        tick(); chk("rmid_b", 32'(Next), 32'd0);
        tick(); chk("rmid_c", 32'(Next), 32'd0);
        reset = 1'b0;
        #1;
        chk("rmid_next", 32'(Next), 32'd0);
        chk("rmid_done", 32'(Done), 32'd0);
        chk("rmid_data", 32'(input_data), 32'd0);
        tick(); tick();
        chk("rmid_next2", 32'(Next), 32'd0);
        chk("rmid_idle", 32'(dut.u_next_db.state_q), 32'(DB_IDLE));
        reset = 1'b1;
        window("rmid_post", 12, PULSE_AT, 1'b1, 6'd9);
        next_btn = 1'b0;
        window("rmid_rel", 10, 0, 1'b1, 6'd9);

        // Sequence of nine presses
        for (int p = 0; p < 9; p++) begin
            data_sw  = seq_vals[p];
            next_btn = 1'b1;
            window("seq", 8, PULSE_AT, 1'b1, seq_vals[p]);
            next_btn = 1'b0;
            window("seq_rel", 8, 0, 1'b1, seq_vals[p]);
        end
        chk("seq_final", 32'(input_data), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
